// File: rtl/seg_scan_mux_if.sv
// seg_scan_mux_if: bundle of the pattern inputs, scan controls and display
// outputs of the seven-segment scan driver.
//   In        flattened segment patterns, channel k at [k*WIDTH +: WIDTH]
//   Enable    scan enable (0 forces idle / blank)
//   Hold      freeze scanning on the current digit
//   Out       registered segment pattern
//   DigitEn   registered one-hot digit enable, all-zero when blanked
//   Sel       registered index of the current digit
//   FrameDone one-cycle pulse when the scan wraps back to digit 0
// slave  : the driver side (seg_scan_mux)
// master : the side feeding patterns and consuming the display outputs
interface seg_scan_mux_if #(
  parameter int WIDTH    = 7,
  parameter int CHANNELS = 9,
  parameter int SEL_W    = 4
);
  logic [CHANNELS*WIDTH-1:0] In;
  logic                      Enable;
  logic                      Hold;
  logic [WIDTH-1:0]          Out;
  logic [CHANNELS-1:0]       DigitEn;
  logic [SEL_W-1:0]          Sel;
  logic                      FrameDone;

  modport slave (
    input  In, Enable, Hold,
    output Out, DigitEn, Sel, FrameDone
  );

  modport master (
    output In, Enable, Hold,
    input  Out, DigitEn, Sel, FrameDone
  );
endinterface

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexed seven-segment display driver.
// Scans CHANNELS patterns of WIDTH bits onto one shared segment bus, one
// digit per PRESCALE-cycle slot, with BLANK_CYC anti-ghosting blank cycles
// at the start of each slot. All patterns are frozen into a snapshot at the
// start of every frame so a digit never tears while the frame is shown.
// Ports:
//   Clk    system clock, all registers update on its rising edge
//   Reset  synchronous, active-high
//   bus    seg_scan_mux_if.slave (In, Enable, Hold -> Out, DigitEn, Sel,
//          FrameDone), all outputs registered
module seg_scan_mux #(
  parameter int WIDTH     = 7,
  parameter int CHANNELS  = 9,
  parameter int SEL_W     = 4,
  parameter int PRESCALE  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic          Clk,
  input  logic          Reset,
  seg_scan_mux_if.slave bus
);

  localparam int                 CNT_W      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0]   BLANK_LAST = (BLANK_CYC > 0) ? CNT_W'(BLANK_CYC - 1) : '0;
  localparam logic [SEL_W-1:0]   SEL_LAST   = SEL_W'(CHANNELS - 1);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t                    state_p0, state_p1;
  logic [SEL_W-1:0]          sel_p0, sel_p1;
  logic [CNT_W-1:0]          cnt_p0, cnt_p1;
  logic [CHANNELS*WIDTH-1:0] snap_p0, snap_p1;
  logic [WIDTH-1:0]          out_p0, out_p1;
  logic [CHANNELS-1:0]       den_p0, den_p1;
  logic                      frame_p0, frame_p1;
  logic                      vld_p0;
  logic                      snap_ld;
  logic                      sel_bad;

  // Pattern of channel s out of a flattened bank; unreachable indices give 0.
  function automatic logic [WIDTH-1:0] pick(input logic [CHANNELS*WIDTH-1:0] v,
                                             input logic [SEL_W-1:0] s);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (32'(s) == k) r = v[k*WIDTH +: WIDTH];
    end
    return r;
  endfunction

  // One-hot digit enable for index s; out-of-range indices give all-zero.
  function automatic logic [CHANNELS-1:0] onehot(input logic [SEL_W-1:0] s);
    logic [CHANNELS-1:0] r;
    r = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (32'(s) == k) r[k] = 1'b1;
    end
    return r;
  endfunction

  // A Sel outside 0..CHANNELS-1 can only come from corruption; drop to IDLE.
  assign sel_bad = (32'(sel_p1) >= CHANNELS);

  // ---- stage p0: next-state and next-output decode ----
  always_comb begin
    state_p0 = state_p1;
    sel_p0   = sel_p1;
    cnt_p0   = cnt_p1;
    snap_ld  = 1'b0;
    frame_p0 = 1'b0;

    if (!bus.Enable || sel_bad) begin
      state_p0 = IDLE;
      sel_p0   = '0;
      cnt_p0   = '0;
    end else begin
      case (state_p1)
        IDLE: begin
          snap_ld  = 1'b1;
          sel_p0   = '0;
          cnt_p0   = '0;
          state_p0 = (BLANK_CYC == 0) ? SHOW : BLANK;
        end
        BLANK: begin
          cnt_p0 = cnt_p1 + CNT_W'(1);
          if (cnt_p1 == BLANK_LAST) state_p0 = SHOW;
        end
        SHOW: begin
          if (cnt_p1 == CNT_LAST) begin
            cnt_p0 = '0;
            // With Hold the slot simply restarts on the same digit, unblanked.
            if (!bus.Hold) begin
              state_p0 = (BLANK_CYC == 0) ? SHOW : BLANK;
              if (sel_p1 == SEL_LAST) begin
                sel_p0   = '0;
                frame_p0 = 1'b1;
                snap_ld  = 1'b1;
              end else begin
                sel_p0 = sel_p1 + SEL_W'(1);
              end
            end
          end else begin
            cnt_p0 = cnt_p1 + CNT_W'(1);
          end
        end
        default: begin
          state_p0 = IDLE;
          sel_p0   = '0;
          cnt_p0   = '0;
        end
      endcase
    end

    // Out is derived from the snapshot being written, so a wrap straight into
    // SHOW (no blank) already displays the freshly captured pattern.
    snap_p0 = snap_ld ? bus.In : snap_p1;
    vld_p0  = (state_p0 == SHOW);
    out_p0  = vld_p0 ? pick(snap_p0, sel_p0) : '0;
    den_p0  = vld_p0 ? onehot(sel_p0) : '0;
  end

  // ---- stage p1: registered state and outputs ----
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_p1 <= IDLE;
      sel_p1   <= '0;
      cnt_p1   <= '0;
      snap_p1  <= '0;
      out_p1   <= '0;
      den_p1   <= '0;
      frame_p1 <= 1'b0;
    end else begin
      state_p1 <= state_p0;
      sel_p1   <= sel_p0;
      cnt_p1   <= cnt_p0;
      snap_p1  <= snap_p0;
      out_p1   <= out_p0;
      den_p1   <= den_p0;
      frame_p1 <= frame_p0;
    end
  end

  assign bus.Out       = out_p1;
  assign bus.DigitEn   = den_p1;
  assign bus.Sel       = sel_p1;
  assign bus.FrameDone = frame_p1;

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb_seg_scan_mux: directed bench for seg_scan_mux with a small 3-digit
// configuration (PRESCALE=4) in two flavours: one blank cycle per slot
// (dut_a) and no blanking (dut_b). Cycle k means the clock period that
// follows the k-th edge after Enable is first sampled high (edge 0).
module tb_seg_scan_mux;

  localparam logic [6:0] P0 = 7'h06;
  localparam logic [6:0] P1 = 7'h5B;
  localparam logic [6:0] P2 = 7'h4F;

  logic Clk = 1'b0;
  logic Reset;
  int   checks = 0;
  int   errors = 0;

  always #5 Clk = ~Clk;

  seg_scan_mux_if #(.WIDTH(7), .CHANNELS(3), .SEL_W(2)) ba ();
  seg_scan_mux_if #(.WIDTH(7), .CHANNELS(3), .SEL_W(2)) bb ();

  seg_scan_mux #(.WIDTH(7), .CHANNELS(3), .SEL_W(2), .PRESCALE(4), .BLANK_CYC(1)) dut_a (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (ba)
  );

  seg_scan_mux #(.WIDTH(7), .CHANNELS(3), .SEL_W(2), .PRESCALE(4), .BLANK_CYC(0)) dut_b (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bb)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_a(input string tag, input logic [2:0] de, input logic [6:0] out,
                       input logic [1:0] sel, input logic fd);
    chk({tag, "_digiten"}, 32'(ba.DigitEn), 32'(de));
    chk({tag, "_out"}, 32'(ba.Out), 32'(out));
    chk({tag, "_sel"}, 32'(ba.Sel), 32'(sel));
    chk({tag, "_framedone"}, 32'(ba.FrameDone), 32'(fd));
  endtask

  task automatic exp_b(input string tag, input logic [2:0] de, input logic [6:0] out,
                       input logic [1:0] sel, input logic fd);
    chk({tag, "_digiten"}, 32'(bb.DigitEn), 32'(de));
    chk({tag, "_out"}, 32'(bb.Out), 32'(out));
    chk({tag, "_sel"}, 32'(bb.Sel), 32'(sel));
    chk({tag, "_framedone"}, 32'(bb.FrameDone), 32'(fd));
  endtask

  // Reset edge, then the edge that samples Enable=1 (edge 0); ends in cycle 1.
  task automatic start_a();
    Reset      = 1'b1;
    ba.Enable  = 1'b0;
    ba.Hold    = 1'b0;
    ba.In      = {P2, P1, P0};
    tick();
    Reset      = 1'b0;
    ba.Enable  = 1'b1;
    tick();
  endtask

  initial begin
    logic       found;
    logic [1:0] s;
    logic [6:0] pats [3];
    pats[0] = P0;
    pats[1] = P1;
    pats[2] = P2;

    Reset     = 1'b1;
    ba.Enable = 1'b0;
    ba.Hold   = 1'b0;
    ba.In     = '0;
    bb.Enable = 1'b0;
    bb.Hold   = 1'b0;
    bb.In     = '0;
    tick();
    tick();
    exp_a("reset_a", 3'b000, 7'h00, 2'd0, 1'b0);
    exp_b("reset_b", 3'b000, 7'h00, 2'd0, 1'b0);

    // Full frame, ch0 pattern changed mid-frame must only appear next frame.
    start_a();
    exp_a("f_c1_blank", 3'b000, 7'h00, 2'd0, 1'b0);
    for (int c = 2; c <= 4; c++) begin
      tick();
      exp_a("f_ch0", 3'b001, P0, 2'd0, 1'b0);
    end
    tick();
    exp_a("f_c5_blank", 3'b000, 7'h00, 2'd1, 1'b0);
    for (int c = 6; c <= 8; c++) begin
      tick();
      exp_a("f_ch1", 3'b010, P1, 2'd1, 1'b0);
      if (c == 7) ba.In[6:0] = 7'h7F;
    end
    tick();
    exp_a("f_c9_blank", 3'b000, 7'h00, 2'd2, 1'b0);
    for (int c = 10; c <= 12; c++) begin
      tick();
      exp_a("f_ch2", 3'b100, P2, 2'd2, 1'b0);
    end
    tick();
    exp_a("f_c13_wrap", 3'b000, 7'h00, 2'd0, 1'b1);
    tick();
    exp_a("f_c14_newsnap", 3'b001, 7'h7F, 2'd0, 1'b0);

    // Hold from cycle 6 for 10 edges: digit 1 stays lit, no blanks.
    start_a();
    for (int c = 2; c <= 6; c++) tick();
    ba.Hold = 1'b1;
    exp_a("hold_c6", 3'b010, P1, 2'd1, 1'b0);
    for (int c = 7; c <= 16; c++) begin
      tick();
      exp_a("hold_on", 3'b010, P1, 2'd1, 1'b0);
    end
    ba.Hold = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      tick();
      if (ba.Sel == 2'd2) found = 1'b1;
      else chk("hold_tail_digiten", 32'(ba.DigitEn), 32'(3'b010));
    end
    chk("hold_release_seen", 32'(found), 32'(1'b1));
    chk("hold_release_blank", 32'(ba.DigitEn), 32'(3'b000));
    tick();
    exp_a("hold_after_ch2", 3'b100, P2, 2'd2, 1'b0);

    // Enable dropped in cycle 7, then re-enabled with a new ch0 pattern.
    start_a();
    for (int c = 2; c <= 7; c++) tick();
    ba.Enable = 1'b0;
    tick();
    exp_a("dis_c8", 3'b000, 7'h00, 2'd0, 1'b0);
    tick();
    exp_a("dis_c9", 3'b000, 7'h00, 2'd0, 1'b0);
    ba.In[6:0] = 7'h11;
    ba.Enable  = 1'b1;
    tick();
    exp_a("reen_blank", 3'b000, 7'h00, 2'd0, 1'b0);
    tick();
    exp_a("reen_ch0", 3'b001, 7'h11, 2'd0, 1'b0);

    // Reset mid-SHOW of ch1 with Enable and Hold held high.
    start_a();
    for (int c = 2; c <= 7; c++) tick();
    Reset   = 1'b1;
    ba.Hold = 1'b1;
    tick();
    exp_a("midrst", 3'b000, 7'h00, 2'd0, 1'b0);
    Reset = 1'b0;
    tick();
    exp_a("midrst_blank", 3'b000, 7'h00, 2'd0, 1'b0);
    tick();
    exp_a("midrst_ch0", 3'b001, P0, 2'd0, 1'b0);
    ba.Hold   = 1'b0;
    ba.Enable = 1'b0;

    // No-blank variant: every digit lit 4 cycles, FrameDone every 12 cycles.
    Reset = 1'b1;
    tick();
    Reset     = 1'b0;
    bb.In     = {P2, P1, P0};
    bb.Enable = 1'b1;
    tick();
    for (int c = 1; c <= 26; c++) begin
      if (c > 1) tick();
      s = 2'(((c - 1) / 4) % 3);
      exp_b("nb", 3'(3'b001 << s), pats[s], s, (c == 13) || (c == 25));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
